apu_mem_arbiter: RTL and testbench

// - Round-robin arbiter sharing one memory port (BRAM/RAM) between NUM_APUS APU cores.
// - Each APU keeps its native fetch/load/store handshake (address, dataOut, read/writeEnable, readRAM -> dataIn, dataReady, writeAcknowledge).
// - Sits between the APU cluster and the audio memory mux. One transaction is in flight at a time.

---
 rtl/apu_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_apu_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apu_mem_arbiter
// Purpose  : Round-robin arbiter that shares one memory port (BRAM/RAM)
//            between NUM_APUS APU cores. Each APU keeps its native
//            fetch/load/store handshake. Only one transaction is in flight at
//            a time. Every transaction runs IDLE -> ISSUE -> GAP -> IDLE.
// Ports    : clk, rst (async, active-low)
//            apu_* in : address/dataOut/readEnable/writeEnable/readRAM per APU
//            apu_* out: dataIn (broadcast), dataReady / writeAcknowledge
//                       (one-hot, one cycle per transaction)
//            mem_* out: registered address/dataOut/readRAM, read/write strobe
//            mem_* in : dataIn, dataReady, writeAcknowledge
//            timeout_err (only when APU_ARB_TIMEOUT_EN is defined)
// Options  : `define APU_ARB_TIMEOUT_EN adds a watchdog that completes an
//            ISSUE phase itself after TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module apu_mem_arbiter #(
    parameter int NUM_APUS       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_APUS*32-1:0] apu_address,
    input  logic [NUM_APUS*16-1:0] apu_dataOut,
    input  logic [NUM_APUS-1:0]    apu_readEnable,
    input  logic [NUM_APUS-1:0]    apu_writeEnable,
    input  logic [NUM_APUS-1:0]    apu_readRAM,
    output logic [15:0]            apu_dataIn,
    output logic [NUM_APUS-1:0]    apu_dataReady,
    output logic [NUM_APUS-1:0]    apu_writeAcknowledge,
    output logic [31:0]            mem_address,
    output logic [15:0]            mem_dataOut,
    output logic                   mem_readEnable,
    output logic                   mem_writeEnable,
    output logic                   mem_readRAM,
`ifdef APU_ARB_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    input  logic [15:0]            mem_dataIn,
    input  logic                   mem_dataReady,
    input  logic                   mem_writeAcknowledge
);

    localparam int                 IDX_W      = $clog2(NUM_APUS);
    localparam logic [IDX_W:0]     c_NUM_APUS = (IDX_W+1)'(NUM_APUS);
    localparam logic [IDX_W-1:0]   c_LAST_APU = IDX_W'(NUM_APUS-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [IDX_W-1:0]      r_rrPtr;
    logic [IDX_W-1:0]      r_grant;
    logic                  r_isWrite;
    logic [NUM_APUS-1:0]   w_req;
    logic                  w_anyReq;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W:0]        w_idx;
    logic [31:0]           w_selAddr;
    logic [15:0]           w_selData;
    logic                  w_selWrite;
    logic                  w_selReadRAM;
    logic [NUM_APUS-1:0]   w_grantOneHot;
    logic                  w_memDone;
    logic                  w_timeout;
    logic                  w_done;

    assign w_req = apu_readEnable | apu_writeEnable;

    // First requester at or after the round-robin pointer. The index is kept
    // one bit wider so the modulo wrap works for non-power-of-two counts.
    always_comb begin
        w_anyReq = 1'b0;
        w_sel    = r_rrPtr;
        w_idx    = '0;
        for (int k = 0; k < NUM_APUS; k++) begin
            w_idx = {1'b0, r_rrPtr} + (IDX_W+1)'(k);
            if (w_idx >= c_NUM_APUS) begin
                w_idx = w_idx - c_NUM_APUS;
            end
            if (!w_anyReq && w_req[w_idx[IDX_W-1:0]]) begin
                w_anyReq = 1'b1;
                w_sel    = w_idx[IDX_W-1:0];
            end
        end
    end

    // Request fields of the selected APU; a raised writeEnable wins over read.
    always_comb begin
        w_selAddr    = '0;
        w_selData    = '0;
        w_selWrite   = 1'b0;
        w_selReadRAM = 1'b0;
        for (int i = 0; i < NUM_APUS; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_selAddr    = apu_address[i*32 +: 32];
                w_selData    = apu_dataOut[i*16 +: 16];
                w_selWrite   = apu_writeEnable[i];
                w_selReadRAM = apu_readRAM[i];
            end
        end
    end

    assign w_grantOneHot = NUM_APUS'(1) << r_grant;

    // Only the completion strobe matching the operation in flight counts.
    assign w_memDone = r_isWrite ? mem_writeAcknowledge : mem_dataReady;

`ifdef APU_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_issueCnt;

    // Held at zero outside ISSUE, so it reads 0 in the first ISSUE cycle and
    // the abort fires in the TIMEOUT_CYCLES-th ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issueCnt <= '0;
        end else if (r_state != S_ISSUE) begin
            r_issueCnt <= '0;
        end else begin
            r_issueCnt <= r_issueCnt + CNT_W'(1);
        end
    end

    assign w_timeout   = (r_state == S_ISSUE) && !w_memDone && (r_issueCnt == c_TIMEOUT_LAST);
    assign timeout_err = w_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = (r_state == S_ISSUE) && (w_memDone || w_timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState          = r_state;
        apu_dataIn           = '0;
        apu_dataReady        = '0;
        apu_writeAcknowledge = '0;
        case (r_state)
            S_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                apu_dataIn = w_timeout ? 16'h0000 : mem_dataIn;
                if (w_done) begin
                    w_nextState = S_GAP;
                    if (r_isWrite) begin
                        apu_writeAcknowledge = w_grantOneHot;
                    end else begin
                        apu_dataReady = w_grantOneHot;
                    end
                end
            end
            S_GAP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Grant capture and memory-port registers. The granted APU is sampled
    // only at the grant edge; later changes on its inputs are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rrPtr         <= '0;
            r_grant         <= '0;
            r_isWrite       <= 1'b0;
            mem_address     <= '0;
            mem_dataOut     <= '0;
            mem_readRAM     <= 1'b0;
            mem_readEnable  <= 1'b0;
            mem_writeEnable <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_grant         <= w_sel;
                        r_isWrite       <= w_selWrite;
                        mem_address     <= w_selAddr;
                        mem_dataOut     <= w_selData;
                        mem_readRAM     <= w_selReadRAM;
                        mem_writeEnable <= w_selWrite;
                        mem_readEnable  <= !w_selWrite;
                    end
                end
                S_ISSUE: begin
                    if (w_done) begin
                        mem_readEnable  <= 1'b0;
                        mem_writeEnable <= 1'b0;
                        r_rrPtr         <= (r_grant == c_LAST_APU) ? '0 : r_grant + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_mem_arbiter
// Purpose  : Self-checking bench for apu_mem_arbiter: reset values, a table
//            of single transactions, fairness, reset during ISSUE, and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_mem_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*32-1:0]   apu_address;
    logic [N*16-1:0]   apu_dataOut;
    logic [N-1:0]      apu_readEnable;
    logic [N-1:0]      apu_writeEnable;
    logic [N-1:0]      apu_readRAM;
    logic [15:0]       apu_dataIn;
    logic [N-1:0]      apu_dataReady;
    logic [N-1:0]      apu_writeAcknowledge;
    logic [31:0]       mem_address;
    logic [15:0]       mem_dataOut;
    logic              mem_readEnable;
    logic              mem_writeEnable;
    logic              mem_readRAM;
    logic [15:0]       mem_dataIn;
    logic              mem_dataReady;
    logic              mem_writeAcknowledge;
`ifdef APU_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apu_mem_arbiter #(.NUM_APUS(N)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .apu_address          (apu_address),
        .apu_dataOut          (apu_dataOut),
        .apu_readEnable       (apu_readEnable),
        .apu_writeEnable      (apu_writeEnable),
        .apu_readRAM          (apu_readRAM),
        .apu_dataIn           (apu_dataIn),
        .apu_dataReady        (apu_dataReady),
        .apu_writeAcknowledge (apu_writeAcknowledge),
        .mem_address          (mem_address),
        .mem_dataOut          (mem_dataOut),
        .mem_readEnable       (mem_readEnable),
        .mem_writeEnable      (mem_writeEnable),
        .mem_readRAM          (mem_readRAM),
`ifdef APU_ARB_TIMEOUT_EN
        .timeout_err          (timeout_err),
`endif
        .mem_dataIn           (mem_dataIn),
        .mem_dataReady        (mem_dataReady),
        .mem_writeAcknowledge (mem_writeAcknowledge)
    );

    typedef struct {
        int          apu;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [15:0] data;
        bit          ram;
        int          lat;
        logic [15:0] memData;
        logic [3:0]  expReady;
        logic [3:0]  expAck;
        logic [15:0] expDataIn;
        bit          expMemWe;
    } vec_t;

    vec_t vecs [4];

    // Randomized-run reference model state
    bit          pRd [N];
    bit          pWr [N];
    bit          pRam [N];
    logic [31:0] pAddr [N];
    logic [15:0] pData [N];
    bit          active;
    bit          gap;
    bit          opW;
    bit          gRam;
    int          g;
    int          lat;
    int          elapsed;
    int          ptr;
    int          cand;
    logic [31:0] gAddr;
    logic [15:0] gData;
    bit          fin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clearAll();
        apu_address          = '0;
        apu_dataOut          = '0;
        apu_readEnable       = '0;
        apu_writeEnable      = '0;
        apu_readRAM          = '0;
        mem_dataIn           = '0;
        mem_dataReady        = 1'b0;
        mem_writeAcknowledge = 1'b0;
    endtask

    task automatic setReq(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [15:0] data, input bit ram);
        apu_readEnable[i]       = rd;
        apu_writeEnable[i]      = wr;
        apu_address[32*i +: 32] = addr;
        apu_dataOut[16*i +: 16] = data;
        apu_readRAM[i]          = ram;
    endtask

    // One isolated transaction: IDLE cycle, ISSUE for lat+1 cycles with the
    // opposite completion strobe pulsed as noise, then the GAP cycle.
    task automatic applyVec(input vec_t v);
        @(negedge clk);
        setReq(v.apu, v.rd, v.wr, v.addr, v.data, v.ram);
        #1;
        check("vec_idle_strobes", {apu_dataReady, apu_writeAcknowledge}, 32'h0);
        for (int k = 0; k <= v.lat; k++) begin
            @(negedge clk);
            mem_dataIn = (k == v.lat) ? v.memData : 16'h0BAD;
            if (v.expMemWe) begin
                mem_writeAcknowledge = (k == v.lat);
                mem_dataReady        = (k != v.lat);
            end else begin
                mem_dataReady        = (k == v.lat);
                mem_writeAcknowledge = (k != v.lat);
            end
            #1;
            check("vec_mem_we", mem_writeEnable, v.expMemWe);
            check("vec_mem_re", mem_readEnable, !v.expMemWe);
            check("vec_mem_addr", mem_address, v.addr);
            check("vec_mem_data", mem_dataOut, v.data);
            check("vec_mem_ram", mem_readRAM, v.ram);
            if (k == v.lat) begin
                check("vec_ready", apu_dataReady, v.expReady);
                check("vec_ack", apu_writeAcknowledge, v.expAck);
                check("vec_dataIn", apu_dataIn, v.expDataIn);
            end else begin
                check("vec_early_strobes", {apu_dataReady, apu_writeAcknowledge}, 32'h0);
            end
        end
        @(negedge clk);
        clearAll();
        #1;
        check("vec_gap_enables", {mem_readEnable, mem_writeEnable}, 32'h0);
        check("vec_gap_strobes", {apu_dataReady, apu_writeAcknowledge}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{apu:1, rd:1'b1, wr:1'b0, addr:32'h0000_0040, data:16'h0000, ram:1'b0, lat:1,
                    memData:16'h1234, expReady:4'b0010, expAck:4'b0000, expDataIn:16'h1234, expMemWe:1'b0};
        vecs[1] = '{apu:2, rd:1'b0, wr:1'b1, addr:32'h0000_0010, data:16'hBEEF, ram:1'b1, lat:0,
                    memData:16'h5555, expReady:4'b0000, expAck:4'b0100, expDataIn:16'h5555, expMemWe:1'b1};
        vecs[2] = '{apu:0, rd:1'b1, wr:1'b1, addr:32'hFFFF_FFFC, data:16'h0001, ram:1'b0, lat:2,
                    memData:16'hC3C3, expReady:4'b0000, expAck:4'b0001, expDataIn:16'hC3C3, expMemWe:1'b1};
        vecs[3] = '{apu:3, rd:1'b1, wr:1'b0, addr:32'h8000_0000, data:16'h7E7E, ram:1'b1, lat:3,
                    memData:16'hA5A5, expReady:4'b1000, expAck:4'b0000, expDataIn:16'hA5A5, expMemWe:1'b0};

        // Reset values, with requests and memory strobes active during reset
        clearAll();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        apu_readEnable = '1;
        mem_dataIn     = 16'hFFFF;
        mem_dataReady  = 1'b1;
        #1;
        check("rst_mem_re", mem_readEnable, 1'b0);
        check("rst_mem_we", mem_writeEnable, 1'b0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_data", {mem_dataOut, 15'h0, mem_readRAM}, 32'h0);
        check("rst_strobes", {apu_dataReady, apu_writeAcknowledge}, 32'h0);
        check("rst_dataIn", apu_dataIn, 16'h0);
        @(negedge clk);
        clearAll();
        rst = 1'b1;

        foreach (vecs[i]) applyVec(vecs[i]);

        // Fairness: all APUs reading continuously, memory always ready.
        // The last vector served APU3, so the pointer is back at 0.
        @(negedge clk);
        for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b0, 32'h100 * i, 16'h0, 1'b0);
        mem_dataReady = 1'b1;
        for (int t = 0; t < 2 * N; t++) begin
            @(negedge clk);
            mem_dataIn = 16'hF000 + 16'(t);
            #1;
            check("fair_ready", apu_dataReady, 32'(1) << (t % N));
            check("fair_dataIn", apu_dataIn, 16'hF000 + 16'(t));
            check("fair_addr", mem_address, 32'h100 * (t % N));
            @(negedge clk);
            #1;
            check("fair_gap_quiet", apu_dataReady, 32'h0);
            @(negedge clk);
            #1;
            check("fair_idle_quiet", apu_dataReady, 32'h0);
        end
        clearAll();

        // Serve APU1 so the pointer sits at 2, then abort a read to APU3.
        @(negedge clk);
        setReq(1, 1'b1, 1'b0, 32'h111, 16'h0, 1'b0);
        @(negedge clk);
        mem_dataReady = 1'b1;
        @(negedge clk);
        clearAll();
        @(negedge clk);
        setReq(3, 1'b1, 1'b0, 32'h300, 16'h0, 1'b0);
        @(negedge clk);
        #1;
        check("mid_pre_re", mem_readEnable, 1'b1);
        check("mid_pre_addr", mem_address, 32'h300);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_re", mem_readEnable, 1'b0);
        check("mid_async_addr", mem_address, 32'h0);
        @(negedge clk);
        clearAll();
        mem_dataReady = 1'b1;
        mem_dataIn    = 16'h7777;
        #1;
        check("mid_rst_ready", apu_dataReady, 32'h0);
        check("mid_rst_dataIn", apu_dataIn, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_late_ready", apu_dataReady, 32'h0);
        mem_dataReady = 1'b0;
        setReq(1, 1'b1, 1'b0, 32'h101, 16'h0, 1'b0);
        setReq(3, 1'b1, 1'b0, 32'h303, 16'h0, 1'b0);
        @(negedge clk);
        mem_dataReady = 1'b1;
        #1;
        check("mid_ptr_zero", apu_dataReady, 32'b0010);
        @(negedge clk);
        clearAll();
        rst = 1'b0;

        // Randomized run against a transaction-level model
        for (int i = 0; i < N; i++) begin
            pRd[i] = 1'b0; pWr[i] = 1'b0; pRam[i] = 1'b0; pAddr[i] = '0; pData[i] = '0;
        end
        active = 1'b0; gap = 1'b0; ptr = 0; g = 0; lat = 0; elapsed = 0;
        opW = 1'b0; gRam = 1'b0; gAddr = '0; gData = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!(pRd[i] || pWr[i])) begin
                    if ($urandom_range(0, 99) < 35) begin
                        pWr[i]   = ($urandom_range(0, 1) == 1);
                        pRd[i]   = !pWr[i] || ($urandom_range(0, 3) == 0);
                        pAddr[i] = $urandom;
                        pData[i] = 16'($urandom);
                        pRam[i]  = ($urandom_range(0, 1) == 1);
                    end
                end else if (active && i == g) begin
                    // Granted APU wiggles its fields; the grant must not follow.
                    pAddr[i] = $urandom;
                    pData[i] = 16'($urandom);
                    pRam[i]  = !pRam[i];
                end
                setReq(i, pRd[i], pWr[i], pAddr[i], pData[i], pRam[i]);
            end
            mem_dataIn           = 16'($urandom);
            mem_dataReady        = ($urandom_range(0, 1) == 1);
            mem_writeAcknowledge = ($urandom_range(0, 1) == 1);
            fin = active && (elapsed == lat);
            if (active) begin
                if (opW) mem_writeAcknowledge = fin;
                else     mem_dataReady        = fin;
            end
            #1;
            check("rnd_ready", apu_dataReady, (fin && !opW) ? (32'(1) << g) : 32'h0);
            check("rnd_ack", apu_writeAcknowledge, (fin && opW) ? (32'(1) << g) : 32'h0);
            check("rnd_dataIn", apu_dataIn, active ? {16'h0, mem_dataIn} : 32'h0);
            check("rnd_mem_re", mem_readEnable, active && !opW);
            check("rnd_mem_we", mem_writeEnable, active && opW);
            if (active) begin
                check("rnd_mem_addr", mem_address, gAddr);
                check("rnd_mem_data", mem_dataOut, gData);
                check("rnd_mem_ram", mem_readRAM, gRam);
            end
            // Advance the model by one clock
            if (active) begin
                if (fin) begin
                    active = 1'b0;
                    gap    = 1'b1;
                    ptr    = (g + 1) % N;
                    pRd[g] = 1'b0;
                    pWr[g] = 1'b0;
                end else begin
                    elapsed++;
                end
            end else if (gap) begin
                gap = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    cand = (ptr + k) % N;
                    if (!active && (pRd[cand] || pWr[cand])) begin
                        active  = 1'b1;
                        g       = cand;
                        opW     = pWr[cand];
                        gAddr   = pAddr[cand];
                        gData   = pData[cand];
                        gRam    = pRam[cand];
                        lat     = $urandom_range(0, 3);
                        elapsed = 0;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
